// File: rtl/full_alu_pkg.sv
// Shared constants and control decode for the 32-bit MIPS-style ALU.
package full_alu_pkg;

    localparam int ALU_WIDTH = 32;

    // Named ALUCtrl codes used by the processor datapath
    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_NOR  = 4'd12;
    localparam logic [3:0] ALU_NAND = 4'd13;

    // Per-slice output select (ALUCtrl[1:0])
    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SLT = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic    ainvert;
        logic    bnegate;
        alu_op_e op;
    } alu_ctrl_t;

    // Split the 4-bit control word into its independent fields
    function automatic alu_ctrl_t decode_ctrl(input logic [3:0] ctrl);
        alu_ctrl_t d;
        d.ainvert = ctrl[3];
        d.bnegate = ctrl[2];
        d.op      = alu_op_e'(ctrl[1:0]);
        return d;
    endfunction

endpackage

// File: rtl/full_alu_bit_slice.sv
// One bit of the ALU: optional operand inversion, AND/OR, full adder and
// SLT pass-through. Chained by the top level into a ripple-carry datapath.
module alu_bit_slice
    import full_alu_pkg::*;
(
    input  logic    a,
    input  logic    b,
    input  logic    Ainvert,
    input  logic    Bnegate,
    input  logic    carry_in,
    input  logic    less,
    input  alu_op_e op,
    output logic    result,
    output logic    carry_out,
    output logic    set,
    output logic    overflow
);

    logic w_a;
    logic w_b;
    logic w_sum;

    assign w_a       = a ^ Ainvert;
    assign w_b       = b ^ Bnegate;
    assign w_sum     = w_a ^ w_b ^ carry_in;
    assign carry_out = (w_a & w_b) | (carry_in & (w_a ^ w_b));
    assign set       = w_sum;
    // Only meaningful on the MSB slice: carry into it XOR carry out of it
    assign overflow  = carry_in ^ carry_out;

    // Select the slice output for the requested operation
    always_comb begin
        result = 1'b0;
        case (op)
            OP_AND:  result = w_a & w_b;
            OP_OR:   result = w_a | w_b;
            OP_ADD:  result = w_sum;
            OP_SLT:  result = less;
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/full_alu.sv
// 32-bit ripple-carry ALU with registered Result, Overflow and Zero.
// One operation accepted per cycle, results visible after the next edge.
module full_alu
    import full_alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALUCtrl,
    output logic [WIDTH-1:0] Result,
    output logic             Overflow,
    output logic             Zero
);

    alu_ctrl_t        w_ctrl;
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_less;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_ovf;
    logic             w_overflow;
    logic             w_zero;
    logic             w_unused_bits;

    logic [WIDTH-1:0] r_result;
    logic             r_overflow;
    logic             r_zero;

    assign w_ctrl     = decode_ctrl(ALUCtrl);
    // Subtraction is a + ~b + 1, so Bnegate doubles as the carry-in
    assign w_carry[0] = w_ctrl.bnegate;
    // SLT: sign of the difference corrected by overflow, fed into bit 0 only
    assign w_less     = {{(WIDTH-1){1'b0}}, w_set[WIDTH-1] ^ w_ovf[WIDTH-1]};

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        alu_bit_slice u_slice (
            .a         (a[i]),
            .b         (b[i]),
            .Ainvert   (w_ctrl.ainvert),
            .Bnegate   (w_ctrl.bnegate),
            .carry_in  (w_carry[i]),
            .less      (w_less[i]),
            .op        (w_ctrl.op),
            .result    (w_result[i]),
            .carry_out (w_carry[i+1]),
            .set       (w_set[i]),
            .overflow  (w_ovf[i])
        );
    end

    // Lower-slice set/overflow bits and the final carry-out are not used
    assign w_unused_bits = ^{w_set[WIDTH-2:0], w_ovf[WIDTH-2:0], w_carry[WIDTH]};

    // Overflow is only reported for the arithmetic operations
    always_comb begin
        w_overflow = 1'b0;
        case (w_ctrl.op)
            OP_ADD:  w_overflow = w_ovf[WIDTH-1];
            OP_SLT:  w_overflow = w_ovf[WIDTH-1];
            OP_AND:  w_overflow = 1'b0;
            OP_OR:   w_overflow = 1'b0;
            default: w_overflow = 1'b0;
        endcase
    end

    assign w_zero = (w_result == {WIDTH{1'b0}});

    // Output registers; Zero is captured alongside Result so they never disagree
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result   <= {WIDTH{1'b0}};
            r_overflow <= 1'b0;
            r_zero     <= 1'b1;
        end else begin
            r_result   <= w_result;
            r_overflow <= w_overflow;
            r_zero     <= w_zero;
        end
    end

    assign Result   = r_result;
    assign Overflow = r_overflow;
    assign Zero     = r_zero;

endmodule

// File: tb/tb_full_alu.sv
// Self-checking bench for full_alu: directed vectors, a pipelined random
// stream and asynchronous reset, all checked against an arithmetic model.
module tb_full_alu;
    import full_alu_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ALUCtrl;
    logic [31:0] Result;
    logic        Overflow;
    logic        Zero;

    int n_checks;
    int n_errors;

    logic        have_exp;
    logic [31:0] exp_result;
    logic        exp_ovf;

    full_alu #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .ALUCtrl  (ALUCtrl),
        .Result   (Result),
        .Overflow (Overflow),
        .Zero     (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Reference: operate on (possibly inverted) operands as signed integers
    function automatic void model(input logic [31:0] ta, input logic [31:0] tb_op,
                                  input logic [3:0] c,
                                  output logic [31:0] r, output logic o);
        logic [31:0] ai;
        logic [31:0] bi;
        longint      s;
        ai = c[3] ? ~ta : ta;
        bi = c[2] ? ~tb_op : tb_op;
        s  = longint'($signed(ai)) + longint'($signed(bi)) + (c[2] ? 64'sd1 : 64'sd0);
        o  = 1'b0;
        r  = 32'd0;
        case (c[1:0])
            2'd0: r = ai & bi;
            2'd1: r = ai | bi;
            2'd2: begin
                r = s[31:0];
                o = (s != longint'($signed(s[31:0])));
            end
            default: begin
                r = (s < 0) ? 32'd1 : 32'd0;
                o = (s != longint'($signed(s[31:0])));
            end
        endcase
    endfunction

    task automatic check_pending(input string tag);
        if (have_exp) begin
            check_eq({tag, ".result"}, Result, exp_result);
            check_eq({tag, ".ovf"}, {31'd0, Overflow}, {31'd0, exp_ovf});
            check_eq({tag, ".zero"}, {31'd0, Zero}, {31'd0, (exp_result == 32'd0)});
        end
    endtask

    // Check the previous operation, then present the next one
    task automatic step(input string tag, input logic [31:0] ta, input logic [31:0] tb_op,
                        input logic [3:0] c);
        @(negedge clk);
        check_pending(tag);
        a = ta;
        b = tb_op;
        ALUCtrl = c;
        model(ta, tb_op, c, exp_result, exp_ovf);
        have_exp = 1'b1;
    endtask

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic [3:0]  vc;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        n_checks = 0;
        n_errors = 0;
        have_exp = 1'b0;
        exp_result = 32'd0;
        exp_ovf = 1'b0;
        rst = 1'b1;
        a = 32'd0;
        b = 32'd0;
        ALUCtrl = 4'd0;

        // Reset is applied before any clock edge
        #2;
        check_eq("rst.result", Result, 32'd0);
        check_eq("rst.zero", {31'd0, Zero}, 32'd1);
        check_eq("rst.ovf", {31'd0, Overflow}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        vecs.push_back('{32'h0, 32'h0, ALU_AND});
        vecs.push_back('{32'h2E5C326F, 32'hE4CB8FC0, ALU_AND});
        vecs.push_back('{32'h35557EBF, 32'hCAAA8140, ALU_AND});
        vecs.push_back('{32'h8BE0FD0F, 32'h82FBB168, ALU_OR});
        vecs.push_back('{32'hDD0A68AD, 32'hDD0A68AD, ALU_NAND});
        vecs.push_back('{32'h272E990A, 32'hD8D166F5, ALU_NOR});
        vecs.push_back('{32'h87E32E3E, 32'hFEC03695, ALU_ADD});
        vecs.push_back('{32'h158F663B, 32'hB61D8902, ALU_ADD});
        vecs.push_back('{32'h80502194, 32'h10F69885, ALU_SUB});
        vecs.push_back('{32'h782A27D8, 32'hA82A046B, ALU_SUB});
        vecs.push_back('{32'h5445FAF8, 32'h5445FAF8, ALU_SUB});
        vecs.push_back('{32'hD79DEAC5, 32'h790512EB, ALU_SLT});
        vecs.push_back('{32'h396E5D22, 32'h396E5D23, ALU_SLT});
        vecs.push_back('{32'h00000000, 32'hFFFFFFFF, ALU_SLT});
        vecs.push_back('{32'hFFFFFFFF, 32'h00000000, ALU_SLT});
        vecs.push_back('{32'h1BB33911, 32'hF2A9B9CA, ALU_SLT});
        vecs.push_back('{32'h7FFFFFFF, 32'h00000001, ALU_ADD});
        vecs.push_back('{32'h80000000, 32'h7FFFFFFF, ALU_SLT});
        foreach (vecs[i]) step("dir", vecs[i].va, vecs[i].vb, vecs[i].vc);

        // Spot-check a few documented results independently of the model
        @(negedge clk);
        check_pending("dir_last");
        have_exp = 1'b0;
        a = 32'h80502194; b = 32'h10F69885; ALUCtrl = ALU_SUB;
        @(negedge clk);
        check_eq("sub_doc.result", Result, 32'h6F59890F);
        check_eq("sub_doc.ovf", {31'd0, Overflow}, 32'd1);
        a = 32'hD79DEAC5; b = 32'h790512EB; ALUCtrl = ALU_SLT;
        @(negedge clk);
        check_eq("slt_doc.result", Result, 32'd1);
        check_eq("slt_doc.ovf", {31'd0, Overflow}, 32'd1);

        // Back-to-back random operations, biased toward equal/adjacent operands
        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra + 32'd1;
                2: rb = ra - 32'd1;
                default: rb = $urandom;
            endcase
            step("rnd", ra, rb, 4'($urandom_range(0, 15)));
        end

        // Mid-stream asynchronous reset discards the in-flight result
        step("pre_rst", 32'h00000001, 32'h00000001, ALU_ADD);
        @(posedge clk);
        #1;
        check_eq("pre_rst.result", Result, 32'd2);
        #1;
        rst = 1'b1;
        #1;
        check_eq("async_rst.result", Result, 32'd0);
        check_eq("async_rst.zero", {31'd0, Zero}, 32'd1);
        check_eq("async_rst.ovf", {31'd0, Overflow}, 32'd0);
        have_exp = 1'b0;
        @(negedge clk);
        check_eq("hold_rst.result", Result, 32'd0);
        rst = 1'b0;

        step("post_rst", 32'h7FFFFFFF, 32'h00000001, ALU_ADD);
        step("post_rst", 32'h12345678, 32'h12345678, ALU_SUB);
        step("post_rst", 32'h00000000, 32'h00000000, ALU_AND);
        @(negedge clk);
        check_pending("post_rst_last");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
